vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer SRAM between two users:
  - display scanout, which feeds the VGA driver's colour input;
  - an image-processing write requester.
- Scanout is real-time and prefetches pixels into a small FIFO. Writes get memory cycles whenever the FIFO is healthy.
- Sits between the framebuffer SRAM, the pixel-processing pipeline and the VGA timing driver.

---
 rtl/vga_fb_arbiter.sv | 146 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer SRAM arbiter: real-time scanout prefetch FIFO vs. pixel writer.
// Optional VGA_FB_UNDERRUN_CNT_EN adds a saturating 16-bit underrun cycle counter output.
module vga_fb_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 24,
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 8,
    parameter int LOW_WATER    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [DATA_W-1:0] pix_data,
    output logic              underrun,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = CNT_W + 1;
    localparam logic [CNT_W-1:0]  FULL_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] DEPTH_C   = CRED_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] LOW_C     = CRED_W'(LOW_WATER);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {WAIT_FRAME, FETCH, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic                inflight_reg;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    head_reg, tail_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                underrun_reg;

    logic [CRED_W-1:0]   credit;
    logic                read_grant, write_grant;
    logic                fifo_empty, push, pop, underrun_hit;

    // An outstanding read already owns a FIFO slot, so it counts toward occupancy.
    assign credit       = {1'b0, count_reg} + CRED_W'(inflight_reg);
    assign fifo_empty   = (count_reg == '0);
    assign push         = inflight_reg && !frame_start;
    assign pop          = pix_req && !fifo_empty && !frame_start;
    assign underrun_hit = pix_req && fifo_empty && !frame_start;
    assign pix_data     = fifo_empty ? '0 : fifo_mem[head_reg];
    assign underrun     = underrun_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            state_reg <= WAIT_FRAME;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (frame_start)
            state_next = FETCH;
        else if (state_reg == FETCH && read_grant && rd_addr_reg == LAST_ADDR)
            state_next = DONE;
    end

    always_comb begin
        read_grant  = 1'b0;
        write_grant = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (rst && state_reg == FETCH && credit < DEPTH_C && (credit < LOW_C || !wr_valid))
            read_grant = 1'b1;
        else if (rst && wr_valid)
            write_grant = 1'b1;
        if (read_grant) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr_reg;
        end else if (write_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
        wr_ready = write_grant;
    end

    // frame_start also drops whatever read is in flight, including one issued this cycle.
    always_ff @(posedge clk) begin
        if (!rst || frame_start) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            rd_addr_reg  <= '0;
            inflight_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            if (push)
                tail_reg <= tail_reg + 1'b1;
            if (pop)
                head_reg <= head_reg + 1'b1;
            count_reg    <= count_reg + CNT_W'(push) - CNT_W'(pop);
            inflight_reg <= read_grant;
            if (read_grant && rd_addr_reg != LAST_ADDR)
                rd_addr_reg <= rd_addr_reg + 1'b1;
            if (underrun_hit)
                underrun_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            fifo_mem[tail_reg] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst && push && !pop)
            assert (count_reg != FULL_C);
    end

`ifdef VGA_FB_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            underrun_cnt_reg <= '0;
        else if (underrun_hit && underrun_cnt_reg != 16'hFFFF)
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
    end

    assign underrun_cnt = underrun_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a queue-based scanout/writer model, plus directed literal checks.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;
    localparam int FP     = 16;
    localparam int DEPTH  = 8;
    localparam int LOW    = 4;
    localparam int MEMSZ  = 64;
    localparam logic [DATA_W-1:0] BASE = 24'hA00000;

    logic              clk = 1'b0;
    logic              rst, frame_start, pix_req, wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] pix_data;
    logic              underrun, wr_ready, mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef VGA_FB_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(FP),
        .FIFO_DEPTH(DEPTH), .LOW_WATER(LOW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_req(pix_req),
        .pix_data(pix_data), .underrun(underrun), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef VGA_FB_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    // Environment SRAM: one-cycle read latency, garbage on rdata when not reading.
    logic              sram_load;
    logic [DATA_W-1:0] sram [MEMSZ];
    always @(posedge clk) begin
        if (sram_load) begin
            for (int i = 0; i < MEMSZ; i++) sram[i] <= BASE | DATA_W'(i);
        end else if (mem_en && mem_we) begin
            sram[mem_addr[5:0]] <= mem_wdata;
        end
        mem_rdata <= (mem_en && !mem_we) ? sram[mem_addr[5:0]] : DATA_W'($urandom);
    end

    // Reference model state
    logic [DATA_W-1:0] m_fifo [$];
    logic [DATA_W-1:0] m_mem [MEMSZ];
    int                m_next;
    bit                m_started, m_pend, m_under;
    logic [DATA_W-1:0] m_pend_data;
    int                m_cnt;
    int                n_vec = 0;
    int                n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_next    = 0;
        m_started = 0;
        m_pend    = 0;
        m_under   = 0;
        m_cnt     = 0;
    endtask

    // Apply one cycle of inputs, compare outputs against the model, then advance the model.
    task automatic cycle(input bit r, input bit fs, input bit pr, input bit wv,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        int                credit;
        bit                fetching, rd, wr, hit;
        logic [DATA_W-1:0] exp_pix;
        @(negedge clk);
        rst = r; frame_start = fs; pix_req = pr; wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
        credit   = m_fifo.size() + int'(m_pend);
        fetching = m_started && (m_next < FP);
        rd       = r && fetching && credit < DEPTH && (credit < LOW || !wv);
        wr       = r && wv && !rd;
        exp_pix  = (m_fifo.size() > 0) ? m_fifo[0] : '0;
        check("mem_en", 32'(mem_en), 32'(rd || wr));
        check("wr_ready", 32'(wr_ready), 32'(wr));
        if (rd) begin
            check("rd_we", 32'(mem_we), 32'd0);
            check("rd_addr", 32'(mem_addr), 32'(m_next));
        end
        if (wr) begin
            check("wr_we", 32'(mem_we), 32'd1);
            check("wr_addr", 32'(mem_addr), 32'(wa));
            check("wr_wdata", 32'(mem_wdata), 32'(wd));
        end
        check("pix_data", 32'(pix_data), 32'(exp_pix));
        check("underrun", 32'(underrun), 32'(m_under));
`ifdef VGA_FB_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
        if (!r) begin
            model_reset();
        end else begin
            hit = pr && (m_fifo.size() == 0) && !fs;
            if (wr) m_mem[wa[5:0]] = wd;
            if (fs) begin
                m_fifo.delete();
                m_next    = 0;
                m_started = 1;
                m_pend    = 0;
                m_under   = 0;
            end else begin
                if (pr && m_fifo.size() > 0) void'(m_fifo.pop_front());
                if (m_pend) m_fifo.push_back(m_pend_data);
                if (hit) m_under = 1;
                m_pend = rd;
                if (rd) begin
                    m_pend_data = m_mem[m_next];
                    m_next++;
                end
            end
            if (hit && m_cnt < 65535) m_cnt++;
        end
    endtask

    initial begin
        int pr_pct;
        rst = 0; frame_start = 0; pix_req = 0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        sram_load = 1;
        for (int i = 0; i < MEMSZ; i++) m_mem[i] = BASE | DATA_W'(i);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        sram_load = 0;

        // Reset state
        cycle(0, 0, 0, 1, 19'd33, 24'h1);
        cycle(0, 0, 0, 0, '0, '0);
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_pix", 32'(pix_data), 32'd0);

        // Prefetch 0..7 then stall on a full FIFO
        cycle(1, 1, 0, 0, '0, '0);
        check("fs_idle", 32'(mem_en), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 0, '0, '0);
            check("t1_en", 32'(mem_en), 32'd1);
            check("t1_addr", 32'(mem_addr), 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 0, '0, '0);
            check("t1_full_idle", 32'(mem_en), 32'd0);
        end
        check("t1_head", 32'(pix_data), 32'(BASE));

        // Full FIFO: writes win until occupancy drops below the low-water mark
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 1, 19'(32 + k), DATA_W'($urandom));
            check("t2_wr_ready", 32'(wr_ready), 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1, 0, 1, 1, 19'(40 + k), DATA_W'($urandom));
            check("t2_pop_pix", 32'(pix_data), 32'(BASE + DATA_W'(k)));
            check("t2_pop_wr", 32'(wr_ready), 32'd1);
        end
        cycle(1, 0, 0, 1, 19'd45, DATA_W'($urandom));
        check("t2_read_wins", 32'({mem_en, mem_we, wr_ready}), 32'b100);
        check("t2_read_addr", 32'(mem_addr), 32'd8);

        // Continuous scanout with a busy writer, through to DONE
        cycle(1, 1, 0, 1, 19'd50, DATA_W'($urandom));
        for (int k = 1; k < 10; k++) cycle(1, 0, 0, 1, 19'(32 + k), DATA_W'($urandom));
        for (int k = 0; k < FP; k++) begin
            cycle(1, 0, 1, 1, 19'(32 + (k % 32)), DATA_W'($urandom));
            check("t3_pix", 32'(pix_data), 32'(BASE + DATA_W'(k)));
            check("t3_underrun", 32'(underrun), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 0, 1, 19'(48 + k), DATA_W'($urandom));
            check("t6_done_wr", 32'(wr_ready), 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1, 0, 0, 0, '0, '0);
            check("t6_done_idle", 32'(mem_en), 32'd0);
        end

        // Underrun right after frame_start, cleared by the next frame_start
        cycle(1, 1, 0, 0, '0, '0);
        cycle(1, 0, 1, 0, '0, '0);
        check("t4_pix_zero", 32'(pix_data), 32'd0);
        cycle(1, 0, 0, 0, '0, '0);
        check("t4_underrun_set", 32'(underrun), 32'd1);
`ifdef VGA_FB_UNDERRUN_CNT_EN
        check("t4_cnt", 32'(underrun_cnt), 32'd1);
`endif
        cycle(1, 1, 0, 0, '0, '0);
        cycle(1, 0, 0, 0, '0, '0);
        check("t4_underrun_clr", 32'(underrun), 32'd0);
        check("t5_first_addr", 32'(mem_addr), 32'd0);
`ifdef VGA_FB_UNDERRUN_CNT_EN
        check("t4_cnt_kept", 32'(underrun_cnt), 32'd1);
`endif

        // frame_start while a read is in flight
        cycle(1, 1, 0, 0, '0, '0);
        cycle(1, 0, 0, 0, '0, '0);
        check("t5_restart_addr", 32'({mem_en, mem_we}), 32'b10);
        check("t5_restart_a0", 32'(mem_addr), 32'd0);
        cycle(1, 0, 0, 0, '0, '0);
        check("t5_empty_d", 32'(pix_data), 32'd0);
        cycle(1, 0, 0, 0, '0, '0);
        check("t5_head", 32'(pix_data), 32'(BASE));

        // Randomized traffic
        pr_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: pr_pct = 0;
                    1: pr_pct = 50;
                    2: pr_pct = 90;
                    default: pr_pct = 100;
                endcase
            end
            cycle($urandom_range(0, 599) != 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) < pr_pct,
                  $urandom_range(0, 99) < 60,
                  19'($urandom_range(0, MEMSZ - 1)),
                  DATA_W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
